// File: rtl/vector_dot_mm_if.sv
// Avalon-style slave bus bundle for vector_dot_mm: word address, write/read
// strobes, 32-bit data paths and the vector bank select.
interface vector_dot_mm_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic [31:0]       writedata;
  logic              write;
  logic              read;
  logic [31:0]       readdata;
  logic              b_data;

  modport master (
    output address, writedata, write, read, b_data,
    input  readdata
  );

  modport slave (
    input  address, writedata, write, read, b_data,
    output readdata
  );
endinterface

// File: rtl/vector_dot_mm.sv
// vector_dot_mm: memory-mapped signed dot-product engine.
// Two element banks (A/B) and a small CSR block share one slave bus. A run
// multiplies and accumulates one element pair per clock into an ACC_W-bit
// wrapping accumulator with a sticky signed-overflow flag.
// Optional feature: define VDOT_IRQ_EN to get the irq output and the CTRL
// irq_en bit; without it completion is observed by polling STATUS.
module vector_dot_mm #(
  parameter int VEC_LEN = 8,
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 48
) (
  input  logic           clk,
  input  logic           reset,
`ifdef VDOT_IRQ_EN
  output logic           irq,
`endif
  vector_dot_mm_if.slave bus
);

  localparam int ADDR_W = $clog2(VEC_LEN) + 1;
  localparam int IDX_W  = $clog2(VEC_LEN);
  localparam int LEN_W  = IDX_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(VEC_LEN);
  localparam logic [31:0]      LEN_MAX32 = 32'(VEC_LEN);

  localparam logic [IDX_W-1:0] OFF_CTRL   = IDX_W'(0);
  localparam logic [IDX_W-1:0] OFF_STATUS = IDX_W'(1);
  localparam logic [IDX_W-1:0] OFF_RES_LO = IDX_W'(2);
  localparam logic [IDX_W-1:0] OFF_RES_HI = IDX_W'(3);
  localparam logic [IDX_W-1:0] OFF_LEN    = IDX_W'(4);

  typedef enum logic {IDLE, RUN} state_t;

  // Signed overflow of a two's-complement add: operands agree in sign and
  // the sum does not.
  function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                   input logic signed [ACC_W-1:0] b,
                                   input logic signed [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic                     done_q, done_d;
  logic                     ovf_q, ovf_d;
  logic                     irq_en_q, irq_en_d;
  logic [31:0]              readdata_q, readdata_d;

  logic signed [DATA_W-1:0] mem_a [VEC_LEN];
  logic signed [DATA_W-1:0] mem_b [VEC_LEN];

  logic                     busy;
  logic                     is_csr;
  logic [IDX_W-1:0]         off;
  logic                     ctrl_wr, len_wr, vec_wr;
  logic [31:0]              rdata;
  logic signed [63:0]       acc_sext;

  logic signed [DATA_W-1:0]   a_el_p0, b_el_p0;
  logic signed [2*DATA_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]    prod_ext_p0, sum_p0;

  assign busy   = (state_q == RUN);
  assign is_csr = bus.address[ADDR_W-1];
  assign off    = bus.address[ADDR_W-2:0];

  assign ctrl_wr = bus.write && is_csr && (off == OFF_CTRL);
  assign len_wr  = bus.write && is_csr && (off == OFF_LEN);
  assign vec_wr  = bus.write && !is_csr && !busy;

  // Stage p0: operand fetch at idx, full-precision product, accumulate.
  assign a_el_p0     = mem_a[idx_q];
  assign b_el_p0     = mem_b[idx_q];
  assign prod_p0     = (2*DATA_W)'(a_el_p0) * (2*DATA_W)'(b_el_p0);
  assign prod_ext_p0 = ACC_W'(prod_p0);
  assign sum_p0      = acc_q + prod_ext_p0;

  assign acc_sext = 64'(acc_q);

  // Next-state logic for the run FSM and all CSR state.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    len_d    = len_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;

    if (ctrl_wr) begin
`ifdef VDOT_IRQ_EN
      irq_en_d = bus.writedata[1];
`else
      irq_en_d = 1'b0;
`endif
      if (bus.writedata[2] && !busy) done_d = 1'b0;
    end

    if (len_wr && !busy) begin
      if (bus.writedata == 32'd0 || bus.writedata > LEN_MAX32) len_d = LEN_MAX;
      else len_d = bus.writedata[LEN_W-1:0];
    end

    case (state_q)
      IDLE: begin
        if (ctrl_wr && bus.writedata[0]) begin
          state_d = RUN;
          acc_d   = '0;
          idx_d   = '0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        acc_d = sum_p0;
        idx_d = idx_q + IDX_W'(1);
        if (add_ovf(acc_q, prod_ext_p0, sum_p0)) ovf_d = 1'b1;
        if ({1'b0, idx_q} == LEN_W'(len_q - LEN_W'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read mux over pre-write state; captured into readdata only when read is high.
  always_comb begin
    rdata = 32'd0;
    if (!is_csr) begin
      rdata = bus.b_data ? 32'(mem_b[off]) : 32'(mem_a[off]);
    end else begin
      case (off)
        OFF_CTRL:   rdata = {29'd0, 1'b0, irq_en_q, 1'b0};
        OFF_STATUS: rdata = {29'd0, ovf_q, done_q, busy};
        OFF_RES_LO: rdata = acc_sext[31:0];
        OFF_RES_HI: rdata = acc_sext[63:32];
        OFF_LEN:    rdata = 32'(len_q);
        default:    rdata = 32'd0;
      endcase
    end
    readdata_d = bus.read ? rdata : readdata_q;
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      len_q      <= LEN_MAX;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
      readdata_q <= readdata_d;
    end
  end

  // Vector banks: written only while idle, never cleared.
  always_ff @(posedge clk) begin
    if (vec_wr && !bus.b_data) mem_a[off] <= bus.writedata[DATA_W-1:0];
    if (vec_wr &&  bus.b_data) mem_b[off] <= bus.writedata[DATA_W-1:0];
  end

  assign bus.readdata = readdata_q;

`ifdef VDOT_IRQ_EN
  assign irq = done_q & irq_en_q;
`endif

endmodule

// File: tb/tb_vector_dot_mm.sv
// Directed bench for vector_dot_mm: a 48-bit-accumulator instance and a
// 32-bit-accumulator instance receive identical bus traffic.
module tb_vector_dot_mm;

  localparam logic [3:0] A_CTRL   = 4'h8;
  localparam logic [3:0] A_STATUS = 4'h9;
  localparam logic [3:0] A_LO     = 4'hA;
  localparam logic [3:0] A_HI     = 4'hB;
  localparam logic [3:0] A_LEN    = 4'hC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] v;

  vector_dot_mm_if #(.ADDR_W(4)) bus ();
  vector_dot_mm_if #(.ADDR_W(4)) bus32 ();

`ifdef VDOT_IRQ_EN
  logic irq, irq32;
`endif

  vector_dot_mm #(.VEC_LEN(8), .DATA_W(16), .ACC_W(48)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef VDOT_IRQ_EN
    .irq   (irq),
`endif
    .bus   (bus)
  );

  vector_dot_mm #(.VEC_LEN(8), .DATA_W(16), .ACC_W(32)) dut32 (
    .clk   (clk),
    .reset (reset),
`ifdef VDOT_IRQ_EN
    .irq   (irq32),
`endif
    .bus   (bus32)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [31:0] d, input logic bank,
                       input logic w, input logic r);
    bus.address = a;   bus.writedata = d;   bus.b_data = bank;   bus.write = w;   bus.read = r;
    bus32.address = a; bus32.writedata = d; bus32.b_data = bank; bus32.write = w; bus32.read = r;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic bank);
    drive(a, d, bank, 1'b1, 1'b0);
    @(negedge clk);
    drive(a, d, bank, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a, input logic bank, input logic sel,
                    output logic [31:0] data);
    drive(a, 32'd0, bank, 1'b0, 1'b1);
    @(negedge clk);
    drive(a, 32'd0, bank, 1'b0, 1'b0);
    data = sel ? bus32.readdata : bus.readdata;
  endtask

  task automatic rw(input logic [3:0] a, input logic [31:0] d, output logic [31:0] data);
    drive(a, d, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(a, d, 1'b0, 1'b0, 1'b0);
    data = bus.readdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    drive(4'h0, 32'd0, 1'b0, 1'b0, 1'b0);
    idle(3);
    reset = 1'b0;

    // Reset state
    chk("rst_readdata", bus.readdata, 32'h0);
    rd(A_STATUS, 1'b0, 1'b0, v); chk("rst_status", v, 32'h0);
    rd(A_LEN,    1'b0, 1'b0, v); chk("rst_len", v, 32'd8);
    rd(A_LO,     1'b0, 1'b0, v); chk("rst_lo", v, 32'h0);
    rd(A_CTRL,   1'b0, 1'b0, v); chk("rst_ctrl", v, 32'h0);

    // Load A[i] = B[i] = i+1
    for (int i = 0; i < 8; i++) begin
      wr(4'(i), 32'(i + 1), 1'b0);
      wr(4'(i), 32'(i + 1), 1'b1);
    end
    rd(4'd2, 1'b0, 1'b0, v); chk("rd_a2", v, 32'd3);
    rd(4'd7, 1'b1, 1'b0, v); chk("rd_b7", v, 32'd8);

    // Full-length run: busy through E8, done visible from the next read
    wr(A_CTRL, 32'h1, 1'b0);
    idle(7);
    rd(A_STATUS, 1'b0, 1'b0, v); chk("full_busy_at_e8", v, 32'h1);
    rd(A_STATUS, 1'b0, 1'b0, v); chk("full_done", v, 32'h2);
    rd(A_LO, 1'b0, 1'b0, v);     chk("full_lo", v, 32'd204);
    rd(A_HI, 1'b0, 1'b0, v);     chk("full_hi", v, 32'd0);

    // LEN = 3
    wr(A_LEN, 32'd3, 1'b0);
    rd(A_LEN, 1'b0, 1'b0, v);    chk("len3_rd", v, 32'd3);
    wr(A_CTRL, 32'h1, 1'b0);
    idle(2);
    rd(A_STATUS, 1'b0, 1'b0, v); chk("len3_busy", v, 32'h1);
    rd(A_STATUS, 1'b0, 1'b0, v); chk("len3_done", v, 32'h2);
    rd(A_LO, 1'b0, 1'b0, v);     chk("len3_lo", v, 32'd14);

    // LEN clamping
    wr(A_LEN, 32'd0, 1'b0);
    rd(A_LEN, 1'b0, 1'b0, v);    chk("len0_clamp", v, 32'd8);
    wr(A_LEN, 32'd9, 1'b0);
    rd(A_LEN, 1'b0, 1'b0, v);    chk("len9_clamp", v, 32'd8);

    // Negative operand: -3 * 5
    wr(4'd0, 32'h0000FFFD, 1'b0);
    wr(4'd0, 32'd5, 1'b1);
    rd(4'd0, 1'b0, 1'b0, v);     chk("rd_a0_sext", v, 32'hFFFFFFFD);
    wr(A_LEN, 32'd1, 1'b0);
    wr(A_CTRL, 32'h1, 1'b0);
    idle(1);
    rd(A_STATUS, 1'b0, 1'b0, v); chk("neg_status", v, 32'h2);
    rd(A_LO, 1'b0, 1'b0, v);     chk("neg_lo", v, 32'hFFFFFFF1);
    rd(A_HI, 1'b0, 1'b0, v);     chk("neg_hi", v, 32'hFFFFFFFF);

    // clear_done
    wr(A_CTRL, 32'h4, 1'b0);
    rd(A_STATUS, 1'b0, 1'b0, v); chk("clear_done", v, 32'h0);

    // Overflow: 2 * (0x8000 * 0x8000) = 2^31
    wr(4'd0, 32'h8000, 1'b0); wr(4'd1, 32'h8000, 1'b0);
    wr(4'd0, 32'h8000, 1'b1); wr(4'd1, 32'h8000, 1'b1);
    wr(A_LEN, 32'd2, 1'b0);
    wr(A_CTRL, 32'h1, 1'b0);
    idle(2);
    rd(A_STATUS, 1'b0, 1'b1, v); chk("ovf32_status", v, 32'h6);
    rd(A_LO, 1'b0, 1'b1, v);     chk("ovf32_lo", v, 32'h80000000);
    rd(A_HI, 1'b0, 1'b1, v);     chk("ovf32_hi", v, 32'hFFFFFFFF);
    rd(A_STATUS, 1'b0, 1'b0, v); chk("ovf48_status", v, 32'h2);
    rd(A_HI, 1'b0, 1'b0, v);     chk("ovf48_hi", v, 32'h0);

    // Busy protection: vector write, restart and LEN write mid-run ignored
    wr(4'd0, 32'd1, 1'b0); wr(4'd1, 32'd2, 1'b0);
    wr(4'd0, 32'd1, 1'b1); wr(4'd1, 32'd2, 1'b1);
    wr(A_LEN, 32'd8, 1'b0);
    wr(A_CTRL, 32'h1, 1'b0);
    wr(4'd7, 32'd9, 1'b0);
    wr(A_CTRL, 32'h1, 1'b0);
    wr(A_LEN, 32'd2, 1'b0);
    idle(4);
    rd(A_STATUS, 1'b0, 1'b0, v); chk("busy_status_e8", v, 32'h1);
    rd(A_STATUS, 1'b0, 1'b0, v); chk("busy_done", v, 32'h2);
    rd(A_LO, 1'b0, 1'b0, v);     chk("busy_lo", v, 32'd204);
    rd(A_LEN, 1'b0, 1'b0, v);    chk("busy_len", v, 32'd8);
    rd(4'd7, 1'b0, 1'b0, v);     chk("busy_a7", v, 32'd8);

    // Same-cycle read and write returns the pre-write value
    rw(A_LEN, 32'd5, v);         chk("rw_old", v, 32'd8);
    rd(A_LEN, 1'b0, 1'b0, v);    chk("rw_new", v, 32'd5);

    // Partial sum, then reset mid-run
    wr(A_LEN, 32'd8, 1'b0);
    wr(A_CTRL, 32'h1, 1'b0);
    idle(2);
    rd(A_LO, 1'b0, 1'b0, v);     chk("partial_lo", v, 32'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_readdata", bus.readdata, 32'h0);
    rd(A_STATUS, 1'b0, 1'b0, v); chk("midrst_status", v, 32'h0);
    rd(A_LO, 1'b0, 1'b0, v);     chk("midrst_lo", v, 32'h0);
    rd(A_HI, 1'b0, 1'b0, v);     chk("midrst_hi", v, 32'h0);
    rd(A_LEN, 1'b0, 1'b0, v);    chk("midrst_len", v, 32'd8);

`ifdef VDOT_IRQ_EN
    wr(A_CTRL, 32'h2, 1'b0);
    rd(A_CTRL, 1'b0, 1'b0, v);   chk("irq_en_rd", v, 32'h2);
    wr(A_CTRL, 32'h3, 1'b0);
    chk("irq_low_running", {31'd0, irq}, 32'd0);
    idle(8);
    chk("irq_high_done", {31'd0, irq}, 32'd1);
    wr(A_CTRL, 32'h6, 1'b0);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
`else
    wr(A_CTRL, 32'h2, 1'b0);
    rd(A_CTRL, 1'b0, 1'b0, v);   chk("irq_en_absent", v, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
